// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode, ALU op, pc_src and control-state encodings
// Used by the control FSM, the ALU and the datapath.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;

  localparam int ALU_W = 4;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'd2;
  localparam logic [ALU_W-1:0] ALU_AND = 4'd3;
  localparam logic [ALU_W-1:0] ALU_CMP = 4'd4;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;

  typedef enum logic [2:0] {
    CLS_ALU_R, CLS_ALU_I, CLS_LW, CLS_SW, CLS_BEQ, CLS_J, CLS_NONE
  } instr_cls_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_JUMP   = 3'd5
`ifdef ILLEGAL_TRAP_EN
    , ST_HALT = 3'd6
`endif
  } state_e;

endpackage

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - combinational opcode/funct to ALU op, operand select and class
// Unsupported opcode/funct combinations come out as CLS_NONE with illegal set.
module alu_op_decoder
  import mips_pkg::*;
(
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  output logic [ALU_W-1:0] alu_op,
  output logic             alu_src_b,
  output instr_cls_e       cls,
  output logic             illegal
);

  always_comb begin
    alu_op    = ALU_ADD;
    alu_src_b = 1'b0;
    cls       = CLS_NONE;
    case (opcode)
      OP_RTYPE: begin
        cls = CLS_ALU_R;
        case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          default:         cls    = CLS_NONE;
        endcase
      end
      OP_ADDI: begin cls = CLS_ALU_I; alu_op = ALU_ADD; alu_src_b = 1'b1; end
      OP_ANDI: begin cls = CLS_ALU_I; alu_op = ALU_AND; alu_src_b = 1'b1; end
      OP_ORI:  begin cls = CLS_ALU_I; alu_op = ALU_OR;  alu_src_b = 1'b1; end
      OP_LW:   begin cls = CLS_LW;    alu_op = ALU_ADD; alu_src_b = 1'b1; end
      OP_SW:   begin cls = CLS_SW;    alu_op = ALU_ADD; alu_src_b = 1'b1; end
      OP_BEQ:  begin cls = CLS_BEQ;   alu_op = ALU_CMP; end
      OP_J:    cls = CLS_J;
      default: cls = CLS_NONE;
    endcase
    illegal = (cls == CLS_NONE);
  end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// rtl/mips_ctrl_fsm.sv - multicycle MIPS control FSM driving alu_op and datapath strobes
// Define ILLEGAL_TRAP_EN to halt on an illegal instruction until rst instead of continuing.
module mips_ctrl_fsm
  import mips_pkg::*;
#(
  parameter int ALU_LATENCY = 1,
  parameter int OPW         = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    instr,
  input  logic           mem_ready,
  input  logic           zero,
  output logic [OPW-1:0] alu_op,
  output logic           alu_src_b,
  output logic           reg_dst,
  output logic           reg_write,
  output logic           mem_read,
  output logic           mem_write,
  output logic           mem_to_reg,
  output logic           ir_write,
  output logic           pc_write,
  output logic [1:0]     pc_src,
  output logic           illegal
);

  localparam int CW = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;

  state_e           state, state_nx;
  logic [5:0]       op_q, fn_q;
  logic [CW-1:0]    lat_cnt;
  logic [ALU_W-1:0] dec_alu_op;
  logic             dec_src_b, dec_illegal;
  instr_cls_e       dec_cls;
  logic             unused_instr;

  assign unused_instr = ^instr[25:6];

  alu_op_decoder u_dec (
    .opcode    (op_q),
    .funct     (fn_q),
    .alu_op    (dec_alu_op),
    .alu_src_b (dec_src_b),
    .cls       (dec_cls),
    .illegal   (dec_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_FETCH;
      op_q    <= '0;
      fn_q    <= '0;
      lat_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_FETCH && mem_ready) begin
        op_q <= instr[31:26];
        fn_q <= instr[5:0];
      end
      // Counter runs down across EXEC so zero is only consumed once the ALU result is valid.
      if (state_nx == ST_EXEC && state != ST_EXEC)
        lat_cnt <= CW'(ALU_LATENCY);
      else if (state == ST_EXEC && lat_cnt != '0)
        lat_cnt <= lat_cnt - CW'(1);
    end
  end

  always_comb begin
    state_nx   = state;
    alu_op     = '0;
    alu_src_b  = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SEQ;
    illegal    = 1'b0;
    if (!rst) begin
      case (state)
        ST_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_nx = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (dec_illegal) begin
            illegal = 1'b1;
`ifdef ILLEGAL_TRAP_EN
            state_nx = ST_HALT;
`else
            state_nx = ST_FETCH;
`endif
          end else if (dec_cls == CLS_J) begin
            state_nx = ST_JUMP;
          end else begin
            state_nx = ST_EXEC;
          end
        end
        ST_EXEC: begin
          alu_op    = OPW'(dec_alu_op);
          alu_src_b = dec_src_b;
          if (lat_cnt == '0) begin
            case (dec_cls)
              CLS_LW, CLS_SW: state_nx = ST_MEM;
              CLS_BEQ: begin
                pc_write = zero;
                pc_src   = zero ? PC_BR : PC_SEQ;
                state_nx = ST_FETCH;
              end
              default: state_nx = ST_WB;
            endcase
          end
        end
        ST_MEM: begin
          mem_read  = (dec_cls == CLS_LW);
          mem_write = (dec_cls != CLS_LW);
          if (mem_ready) state_nx = (dec_cls == CLS_LW) ? ST_WB : ST_FETCH;
        end
        ST_WB: begin
          reg_write  = 1'b1;
          reg_dst    = (dec_cls == CLS_ALU_R);
          mem_to_reg = (dec_cls == CLS_LW);
          state_nx   = ST_FETCH;
        end
        ST_JUMP: begin
          pc_write = 1'b1;
          pc_src   = PC_JMP;
          state_nx = ST_FETCH;
        end
`ifdef ILLEGAL_TRAP_EN
        ST_HALT: state_nx = ST_HALT;
`endif
        default: state_nx = ST_FETCH;
      endcase
    end
  end

endmodule
